// File: rtl/wavetable_reader.sv
// Phase-accumulator wavetable oscillator with linear interpolation between adjacent ROM samples.
// Latency: tick accepted at edge 0, sample_valid pulses 5 cycles later (one accept per 5 cycles max).
// Backpressure: none upstream; a tick arriving while busy is dropped and latches the sticky overrun flag.
module wavetable_reader #(
    parameter int ADDRWIDTH  = 12,
    parameter int WIDTH      = 16,
    parameter int PHASEWIDTH = 32,
    parameter int FRACBITS   = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  sample_tick,
    input  logic [PHASEWIDTH-1:0] phase_inc,
    input  logic                  phase_reset,
    output logic                  rom_cs,
    output logic [ADDRWIDTH-1:0]  rom_addr,
    input  logic [WIDTH-1:0]      rom_data,
    output logic [WIDTH-1:0]      sample_out,
    output logic                  sample_valid,
    output logic                  busy,
    output logic                  overrun
);

    // Fetch sequence: two back-to-back ROM reads, two captures, one interpolation.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH0 = 3'd1;
    localparam logic [2:0] S_FETCH1 = 3'd2;
    localparam logic [2:0] S_CAPT1  = 3'd3;
    localparam logic [2:0] S_CALC   = 3'd4;

    // Product width: signed (WIDTH+1)-bit difference times zero-extended (FRACBITS+1)-bit fraction.
    localparam int PRODW = WIDTH + FRACBITS + 2;

    localparam logic [ADDRWIDTH-1:0] ADDR_ONE = ADDRWIDTH'(1);

    logic [2:0]            state_q,    state_d;
    logic [PHASEWIDTH-1:0] phase_q,    phase_d;
    logic [ADDRWIDTH-1:0]  idx_q,      idx_d;
    logic [FRACBITS-1:0]   frac_q,     frac_d;
    logic [ADDRWIDTH-1:0]  rom_addr_q, rom_addr_d;
    logic                  rom_cs_q,   rom_cs_d;
    logic [WIDTH-1:0]      s0_q,       s0_d;
    logic [WIDTH-1:0]      s1_q,       s1_d;
    logic [WIDTH-1:0]      sample_q,   sample_d;
    logic                  valid_q,    valid_d;
    logic                  overrun_q,  overrun_d;

    // Phase seen by an accepted tick: phase_reset restarts it at zero in the same cycle.
    logic [PHASEWIDTH-1:0] phase_base;
    logic                  is_idle;

    logic signed [PRODW-1:0] s0_ext;
    logic signed [PRODW-1:0] s1_ext;
    logic signed [PRODW-1:0] diff_w;
    logic signed [PRODW-1:0] frac_w;
    logic signed [PRODW-1:0] prod_w;
    logic [WIDTH-1:0]        interp_w;

    assign is_idle    = (state_q == S_IDLE);
    assign phase_base = phase_reset ? '0 : phase_q;

    // Interpolation datapath: s0 + floor((s1-s0)*frac / 2**FRACBITS); result never leaves [s0,s1].
    always_comb begin
        s0_ext   = {{(PRODW-WIDTH){s0_q[WIDTH-1]}}, s0_q};
        s1_ext   = {{(PRODW-WIDTH){s1_q[WIDTH-1]}}, s1_q};
        frac_w   = {{(PRODW-FRACBITS){1'b0}}, frac_q};
        diff_w   = s1_ext - s0_ext;
        prod_w   = diff_w * frac_w;
        // Arithmetic shift floors toward -inf, so negative slopes round down, not toward zero.
        interp_w = WIDTH'(s0_ext + (prod_w >>> FRACBITS));
    end

    // Next-state logic: tick acceptance, phase advance, ROM request sequencing and capture.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        idx_d      = idx_q;
        frac_d     = frac_q;
        rom_addr_d = rom_addr_q;
        rom_cs_d   = rom_cs_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        overrun_d  = overrun_q;

        // A restart request without an accepted tick still clears the phase.
        if (phase_reset) begin
            phase_d = '0;
        end

        // Ticks landing mid-fetch are dropped; the in-flight fetch carries on untouched.
        if (sample_tick && !is_idle) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                rom_cs_d = 1'b0;
                if (sample_tick) begin
                    phase_d    = phase_base + phase_inc;
                    idx_d      = phase_base[PHASEWIDTH-1 -: ADDRWIDTH];
                    frac_d     = phase_base[PHASEWIDTH-ADDRWIDTH-1 -: FRACBITS];
                    rom_addr_d = phase_base[PHASEWIDTH-1 -: ADDRWIDTH];
                    rom_cs_d   = 1'b1;
                    state_d    = S_FETCH0;
                end
            end
            S_FETCH0: begin
                // Second tap; the last table entry pairs with entry zero.
                rom_addr_d = idx_q + ADDR_ONE;
                rom_cs_d   = 1'b1;
                state_d    = S_FETCH1;
            end
            S_FETCH1: begin
                // ROM registered the first address last edge, so its data is mem[idx] now.
                s0_d     = rom_data;
                rom_cs_d = 1'b0;
                state_d  = S_CAPT1;
            end
            S_CAPT1: begin
                s1_d    = rom_data;
                state_d = S_CALC;
            end
            S_CALC: begin
                sample_d = interp_w;
                valid_d  = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                rom_cs_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any fetch without emitting a sample.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            idx_q      <= '0;
            frac_q     <= '0;
            rom_addr_q <= '0;
            rom_cs_q   <= 1'b0;
            s0_q       <= '0;
            s1_q       <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            frac_q     <= frac_d;
            rom_addr_q <= rom_addr_d;
            rom_cs_q   <= rom_cs_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rom_cs       = rom_cs_q;
    assign rom_addr     = rom_addr_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign busy         = !is_idle;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_wavetable_reader.sv
// Bench for wavetable_reader: synchronous ROM model, directed vector table, random ticks vs reference model.
// Latency: checks the 5-cycle tick-to-sample timing and the two ROM addresses of each fetch.
// Backpressure: exercises dropped ticks (overrun) and reset in the middle of a fetch.
module tb_wavetable_reader;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        sample_tick;
    logic [31:0] phase_inc;
    logic        phase_reset;
    logic        rom_cs;
    logic [11:0] rom_addr;
    logic [15:0] rom_data = 16'h0;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        busy;
    logic        overrun;

    logic [15:0] mem [0:4095];

    int checks = 0;
    int errors = 0;

    // Reference model state: phase as a plain 32-bit number, sticky overrun flag.
    logic [31:0] m_phase = 32'h0;
    logic        m_ovr   = 1'b0;

    typedef struct {
        logic        pr;
        logic [31:0] inc;
        logic        wen;
        logic [11:0] wa0;
        logic [15:0] wv0;
        logic [11:0] wa1;
        logic [15:0] wv1;
        logic [11:0] ea0;
        logic [11:0] ea1;
        logic [15:0] es;
    } vec_t;

    vec_t vecs [0:12];

    wavetable_reader #(
        .ADDRWIDTH (12),
        .WIDTH     (16),
        .PHASEWIDTH(32),
        .FRACBITS  (8)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .sample_tick (sample_tick),
        .phase_inc   (phase_inc),
        .phase_reset (phase_reset),
        .rom_cs      (rom_cs),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 Clk = ~Clk;

    // Synchronous ROM: one-cycle registered read when selected.
    always @(posedge Clk) begin
        if (rom_cs) rom_data <= mem[rom_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            chk("idle_valid", 32'(sample_valid), 32'h0);
        end
    endtask

    // Issues one tick at the current negedge (cycle 0) and checks through cycle 5.
    // dup adds a second tick in cycle 2, which must be dropped.
    task automatic do_tick(input logic pr, input logic [31:0] inc, input logic dup,
                           input logic use_exp, input logic [11:0] ea0, input logic [11:0] ea1,
                           input logic [15:0] es);
        logic [31:0] p;
        logic [11:0] ix;
        logic [11:0] ix1;
        logic [7:0]  fr;
        int a, b, prod, q;
        logic [11:0] x0, x1;
        logic [15:0] xs;

        p   = pr ? 32'h0 : m_phase;
        ix  = p[31:20];
        fr  = p[19:12];
        ix1 = ix + 12'd1;
        m_phase = p + inc;
        a    = int'($signed(mem[ix]));
        b    = int'($signed(mem[ix1]));
        prod = (b - a) * int'(fr);
        q    = prod / 256;
        if ((prod % 256) != 0 && prod < 0) q = q - 1;
        if (dup) m_ovr = 1'b1;
        x0 = use_exp ? ea0 : ix;
        x1 = use_exp ? ea1 : ix1;
        xs = use_exp ? es  : 16'(a + q);

        sample_tick = 1'b1;
        phase_reset = pr;
        phase_inc   = inc;
        @(negedge Clk);   // cycle 1
        sample_tick = 1'b0;
        phase_reset = 1'b0;
        chk("c1_busy",  32'(busy), 32'h1);
        chk("c1_cs",    32'(rom_cs), 32'h1);
        chk("c1_addr",  32'(rom_addr), 32'(x0));
        chk("c1_valid", 32'(sample_valid), 32'h0);
        @(negedge Clk);   // cycle 2
        chk("c2_cs",    32'(rom_cs), 32'h1);
        chk("c2_addr",  32'(rom_addr), 32'(x1));
        if (dup) begin
            sample_tick = 1'b1;
            phase_inc   = 32'hDEAD0000;
        end
        @(negedge Clk);   // cycle 3
        sample_tick = 1'b0;
        chk("c3_cs",    32'(rom_cs), 32'h0);
        chk("c3_valid", 32'(sample_valid), 32'h0);
        @(negedge Clk);   // cycle 4
        chk("c4_valid", 32'(sample_valid), 32'h0);
        chk("c4_busy",  32'(busy), 32'h1);
        @(negedge Clk);   // cycle 5
        chk("c5_valid",   32'(sample_valid), 32'h1);
        chk("c5_sample",  32'(sample_out), 32'(xs));
        chk("c5_busy",    32'(busy), 32'h0);
        chk("c5_overrun", 32'(overrun), 32'(m_ovr));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'(i);

        //          pr    inc            wen   wa0      wv0       wa1      wv1       ea0      ea1      es
        vecs[0]  = '{1'b0, 32'h00100000, 1'b0, 12'h000, 16'h0000, 12'h000, 16'h0000, 12'h000, 12'h001, 16'h0000};
        vecs[1]  = '{1'b0, 32'h00100000, 1'b0, 12'h000, 16'h0000, 12'h000, 16'h0000, 12'h001, 12'h002, 16'h0001};
        vecs[2]  = '{1'b0, 32'h00100000, 1'b0, 12'h000, 16'h0000, 12'h000, 16'h0000, 12'h002, 12'h003, 16'h0002};
        vecs[3]  = '{1'b0, 32'h00100000, 1'b0, 12'h000, 16'h0000, 12'h000, 16'h0000, 12'h003, 12'h004, 16'h0003};
        vecs[4]  = '{1'b1, 32'h00080000, 1'b1, 12'h000, 16'h0000, 12'h001, 16'h0064, 12'h000, 12'h001, 16'h0000};
        vecs[5]  = '{1'b0, 32'h00080000, 1'b0, 12'h000, 16'h0000, 12'h000, 16'h0000, 12'h000, 12'h001, 16'h0032};
        vecs[6]  = '{1'b1, 32'h00540000, 1'b1, 12'h005, 16'h0010, 12'h006, 16'hFFF0, 12'h000, 12'h001, 16'h0000};
        vecs[7]  = '{1'b0, 32'h00000000, 1'b0, 12'h000, 16'h0000, 12'h000, 16'h0000, 12'h005, 12'h006, 16'h0008};
        vecs[8]  = '{1'b1, 32'h00501000, 1'b0, 12'h000, 16'h0000, 12'h000, 16'h0000, 12'h000, 12'h001, 16'h0000};
        vecs[9]  = '{1'b0, 32'h00000000, 1'b0, 12'h000, 16'h0000, 12'h000, 16'h0000, 12'h005, 12'h006, 16'h000F};
        vecs[10] = '{1'b1, 32'hFFF80000, 1'b0, 12'h000, 16'h0000, 12'h000, 16'h0000, 12'h000, 12'h001, 16'h0000};
        vecs[11] = '{1'b0, 32'h00100000, 1'b1, 12'hFFF, 16'h1000, 12'h000, 16'h2000, 12'hFFF, 12'h000, 16'h1800};
        vecs[12] = '{1'b0, 32'h00000000, 1'b0, 12'h000, 16'h0000, 12'h000, 16'h0000, 12'h000, 12'h001, 16'h1032};

        Reset       = 1'b1;
        sample_tick = 1'b0;
        phase_inc   = 32'h0;
        phase_reset = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_cs",      32'(rom_cs), 32'h0);
        chk("rst_addr",    32'(rom_addr), 32'h0);
        chk("rst_sample",  32'(sample_out), 32'h0);
        chk("rst_valid",   32'(sample_valid), 32'h0);
        chk("rst_busy",    32'(busy), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        Reset = 1'b0;
        @(negedge Clk);

        // Directed table: ramp, positive slope, negative slope with floor, table wrap.
        for (int v = 0; v < 13; v++) begin
            if (vecs[v].wen) begin
                mem[vecs[v].wa0] = vecs[v].wv0;
                mem[vecs[v].wa1] = vecs[v].wv1;
            end
            do_tick(vecs[v].pr, vecs[v].inc, 1'b0, 1'b1, vecs[v].ea0, vecs[v].ea1, vecs[v].es);
            idle(3);
        end

        // Dropped tick in cycle 2, then a tick exactly in cycle 5 which must be accepted.
        do_tick(1'b0, 32'h00123456, 1'b1, 1'b0, 12'h0, 12'h0, 16'h0);
        do_tick(1'b0, 32'h00300000, 1'b0, 1'b0, 12'h0, 12'h0, 16'h0);
        idle(2);
        chk("overrun_sticky", 32'(overrun), 32'h1);

        // Random table contents and tuning words against the reference model.
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        for (int n = 0; n < 40; n++) begin
            do_tick(($urandom_range(0, 7) == 0), $urandom, 1'b0, 1'b0, 12'h0, 12'h0, 16'h0);
            idle($urandom_range(0, 3));
        end

        // Reset in cycle 2 of a fetch: no sample, everything cleared, next fetch starts at idx 0.
        sample_tick = 1'b1;
        phase_inc   = 32'h01230000;
        @(negedge Clk);
        sample_tick = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        m_phase = 32'h0;
        m_ovr   = 1'b0;
        chk("mid_rst_cs",      32'(rom_cs), 32'h0);
        chk("mid_rst_addr",    32'(rom_addr), 32'h0);
        chk("mid_rst_sample",  32'(sample_out), 32'h0);
        chk("mid_rst_valid",   32'(sample_valid), 32'h0);
        chk("mid_rst_busy",    32'(busy), 32'h0);
        chk("mid_rst_overrun", 32'(overrun), 32'h0);
        idle(5);
        do_tick(1'b0, 32'h00100000, 1'b0, 1'b0, 12'h0, 12'h0, 16'h0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wavetable_reader.md
Name: wavetable_reader

Overview:
Phase-accumulator oscillator that fetches samples from the synchronous wavetable ROM and produces one linearly interpolated audio sample per sample tick. It acts as the requester on the ROM read port: it drives CS and the address, and absorbs the ROM's one-cycle registered read latency. It sits between the sample-rate tick generator and the voice mixer.

Parameters:
ADDRWIDTH, 12, ROM address width (table length 2**ADDRWIDTH)
WIDTH, 16, sample width (two's complement signed)
PHASEWIDTH, 32, phase accumulator width; must be >= ADDRWIDTH+FRACBITS
FRACBITS, 8, interpolation fraction bits taken from the phase

Ports:
Clk  in  1  system clock; all logic on the rising edge
Reset  in  1  synchronous, active-high reset
sample_tick  in  1  one-cycle request for a new sample
phase_inc  in  PHASEWIDTH  tuning word; sampled when a tick is accepted
phase_reset  in  1  restart the phase at 0
rom_cs  out  1  ROM chip select (registered)
rom_addr  out  ADDRWIDTH  ROM address (registered)
rom_data  in  WIDTH  ROM data; valid one cycle after the ROM samples cs=1 and the address
sample_out  out  WIDTH  interpolated signed sample; held between updates
sample_valid  out  1  one-cycle pulse when sample_out updates
busy  out  1  high while state != IDLE
overrun  out  1  sticky; a tick arrived while busy

Behaviour:
- Reset (synchronous, overrides everything): state=IDLE, phase=0, rom_cs=0, rom_addr=0, sample_out=0, sample_valid=0, overrun=0, s0=s1=0. An in-flight fetch is abandoned with no sample_valid.
- Phase: P = current phase; idx = P[PHASEWIDTH-1 -: ADDRWIDTH]; frac = P[PHASEWIDTH-ADDRWIDTH-1 -: FRACBITS], unsigned.
- Tick accept: only in IDLE. At the accepting edge, P is latched (P=0 if phase_reset=1), phase <= P+phase_inc mod 2**PHASEWIDTH, rom_addr <= idx, rom_cs <= 1, state <= FETCH0.
- phase_reset without an accepted tick: phase <= 0.
- FETCH0 (cycle 1): rom_addr <= idx+1 mod 2**ADDRWIDTH (idx all-ones wraps to 0), rom_cs stays 1, -> FETCH1.
- FETCH1 (cycle 2): s0 <= rom_data (mem[idx]), rom_cs <= 0, -> CAPT1.
- CAPT1 (cycle 3): s1 <= rom_data (mem[idx+1]), -> CALC.
- CALC (cycle 4): sample_out <= s0 + floor(((s1-s0)*frac) / 2**FRACBITS), sample_valid <= 1, -> IDLE.
- Latency: tick in cycle 0 -> sample_valid high in cycle 5. Maximum accept rate is one tick per 5 cycles; a tick in cycle 5 is accepted.
- Arithmetic: diff is signed WIDTH+1 bits; frac is zero-extended; the product is full width; the shift is arithmetic right by FRACBITS (floor toward -inf). The result always lies within [min(s0,s1), max(s0,s1)] and is truncated to WIDTH without overflow.
- Tick while busy: dropped. Phase is not advanced, overrun <= 1 (cleared only by Reset), and the in-flight fetch is unaffected.
- While IDLE: rom_cs=0 and rom_addr holds its last value. ROM data is never captured unless rom_cs was 1 at the prior edge.
- sample_valid is high for exactly one cycle per accepted tick.

Test Plan:
- Reset, phase_inc=0x00100000, mem[i]=i, ticks every 8 cycles -> sample_out 0,1,2,3...; rom_addr pairs (0,1),(1,2)...; each sample_valid exactly 5 cycles after its tick.
- phase_inc=0x00080000, mem[0]=0, mem[1]=100 -> 1st sample 0; 2nd (P=0x00080000, frac=0x80) = 50.
- Negative slope: phase_reset then phase_inc=0x00540000, mem[5]=0x0010, mem[6]=0xFFF0; 2nd tick (frac=0x40) -> 0x0008. Same test with frac=0x01 (P=0x00501000) -> 0x000F (floor).
- Wrap: phase forced via the increment sequence to P=0xFFF80000, mem[4095]=0x1000, mem[0]=0x2000 -> rom_addr 0xFFF then 0x000, sample_out=0x1800, and the next phase wraps modulo 2**32.
- Overrun: ticks in cycles 0 and 2 -> one sample_valid (cycle 5), overrun=1 and stays 1, phase advanced once. A tick in cycle 5 is accepted.
- Reset asserted in cycle 2 of a fetch -> no sample_valid; all outputs 0 next cycle; next tick reads idx 0.
